// File: rtl/fetch_queue_if.sv
// Fetch queue handshake bundle.
// Upstream fetch channel plus downstream decode channel.
interface fetch_queue_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 16
);
  logic             in_valid;
  logic [AW-1:0]    in_pc;
  logic [WIDTH-1:0] in_instr;
  logic             in_ready;
  logic             out_valid;
  logic [AW-1:0]    out_pc;
  logic [WIDTH-1:0] out_instr;
  logic             out_ready;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode.
// Circular buffer with optional empty-queue fall-through.
module fetch_queue #(
  parameter int WIDTH  = 16,
  parameter int AW     = 16,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  fetch_queue_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]    r_pc    [DEPTH];
  logic [WIDTH-1:0] r_instr [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic w_empty;
  logic w_full;
  logic w_byp;
  logic w_push;
  logic w_pop;
  logic w_wr;
  logic w_rd;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL);
  assign w_byp   = (BYPASS != 0) && w_empty;

  // ready depends on occupancy only, never on a same-cycle pop
  assign bus.in_ready  = !w_full && !flush;
  assign bus.out_valid = !flush &&
                         (w_empty ? (w_byp && bus.in_valid) : 1'b1);
  assign bus.out_pc    = w_byp ? bus.in_pc    : r_pc[r_rptr];
  assign bus.out_instr = w_byp ? bus.in_instr : r_instr[r_rptr];

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;
  // a bypassed entry consumed this cycle never lands in storage
  assign w_wr   = w_push && !(w_byp && bus.out_ready);
  assign w_rd   = w_pop && !w_empty;

  assign count    = r_count;
  assign overflow = r_ovf;

  // pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + PW'(1);
      if (w_rd)
        r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      if (bus.in_valid && !bus.in_ready)
        r_ovf <= 1'b1;
    end
  end

  // entry storage, not reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_pc[r_wptr]    <= bus.in_pc;
      r_instr[r_wptr] <= bus.in_instr;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue, BYPASS=0 and BYPASS=1 side by side.
// Queue model checked every cycle plus literal pins.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0] in_pc = '0;
  logic [15:0] in_instr = '0;
  logic out_ready = 1'b0;
  logic [2:0] count0, count1;
  logic ovf0, ovf1;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  ent_t q0[$];
  ent_t q1[$];
  bit m_ovf0 = 1'b0;
  bit m_ovf1 = 1'b0;

  always #5 clk = ~clk;

  fetch_queue_if #(.WIDTH(16), .AW(16)) bus0 ();
  fetch_queue_if #(.WIDTH(16), .AW(16)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_pc     = in_pc;
  assign bus0.in_instr  = in_instr;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_pc     = in_pc;
  assign bus1.in_instr  = in_instr;
  assign bus1.out_ready = out_ready;

  fetch_queue #(.WIDTH(16), .AW(16), .DEPTH(DEPTH), .BYPASS(0)) u0 (
    .clk(clk), .reset(reset), .flush(flush),
    .bus(bus0), .count(count0), .overflow(ovf0)
  );

  fetch_queue #(.WIDTH(16), .AW(16), .DEPTH(DEPTH), .BYPASS(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush),
    .bus(bus1), .count(count1), .overflow(ovf1)
  );

  task automatic chk(input string nm, input int b,
                     input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d got %0h want %0h @%0t",
               nm, b, act, exp, $time);
    end
  endtask

  // expected outputs from queue occupancy and current inputs
  task automatic cmp(input int b, input int cnt, input ent_t fr,
                     input bit movf, input logic [2:0] a_cnt,
                     input logic a_rdy, input logic a_ov,
                     input logic [15:0] a_pc, input logic [15:0] a_in,
                     input logic a_ovf);
    bit e_rdy, e_ov;
    logic [15:0] e_pc, e_in;
    e_rdy = (cnt != DEPTH) && !flush;
    if (flush) e_ov = 1'b0;
    else if (cnt != 0) e_ov = 1'b1;
    else e_ov = (b == 1) ? in_valid : 1'b0;
    e_pc = (cnt != 0) ? fr.pc : in_pc;
    e_in = (cnt != 0) ? fr.ins : in_instr;
    chk("m_count", b, 32'(a_cnt), 32'(cnt));
    chk("m_in_ready", b, 32'(a_rdy), 32'(e_rdy));
    chk("m_out_valid", b, 32'(a_ov), 32'(e_ov));
    chk("m_overflow", b, 32'(a_ovf), 32'(movf));
    if (e_ov) begin
      chk("m_out_pc", b, 32'(a_pc), 32'(e_pc));
      chk("m_out_instr", b, 32'(a_in), 32'(e_in));
    end
  endtask

  // what a clean-cycle edge does to a queue of cnt entries
  function automatic void act(input int b, input int cnt,
                              output bit pop, output bit wr,
                              output bit ov);
    bit vis;
    vis = (cnt != 0) || (b == 1 && in_valid);
    pop = vis && out_ready && (cnt != 0);
    wr  = in_valid && (cnt != DEPTH) &&
          !(cnt == 0 && b == 1 && out_ready);
    ov  = in_valid && (cnt == DEPTH);
  endfunction

  // model state update
  always @(posedge clk) begin
    bit p, w, o;
    ent_t e;
    e.pc = in_pc;
    e.ins = in_instr;
    if (reset) begin
      q0.delete(); q1.delete();
      m_ovf0 = 1'b0; m_ovf1 = 1'b0;
      started = 1'b1;
    end else if (flush) begin
      q0.delete(); q1.delete();
      m_ovf0 = 1'b0; m_ovf1 = 1'b0;
    end else begin
      act(0, q0.size(), p, w, o);
      if (p) void'(q0.pop_front());
      if (w) q0.push_back(e);
      if (o) m_ovf0 = 1'b1;
      act(1, q1.size(), p, w, o);
      if (p) void'(q1.pop_front());
      if (w) q1.push_back(e);
      if (o) m_ovf1 = 1'b1;
    end
  end

  // compare DUTs against model every cycle
  always @(negedge clk) begin
    ent_t f0, f1;
    f0 = '0;
    f1 = '0;
    if (q0.size() != 0) f0 = q0[0];
    if (q1.size() != 0) f1 = q1[0];
    if (started) begin
      cmp(0, q0.size(), f0, m_ovf0, count0, bus0.in_ready,
          bus0.out_valid, bus0.out_pc, bus0.out_instr, ovf0);
      cmp(1, q1.size(), f1, m_ovf1, count1, bus1.in_ready,
          bus1.out_valid, bus1.out_pc, bus1.out_instr, ovf1);
    end
  end

  task automatic cyc(input bit r, input bit f, input bit v,
                     input logic [15:0] pc, input bit ordy);
    @(posedge clk);
    #1;
    reset = r;
    flush = f;
    in_valid = v;
    in_pc = pc;
    in_instr = pc ^ 16'h5A00;
    out_ready = ordy;
    #2;
  endtask

  initial begin
    cyc(0, 0, 0, 16'h0, 0);
    chk("rst_count", 0, 32'(count0), 0);
    chk("rst_count", 1, 32'(count1), 0);
    chk("rst_in_ready", 1, 32'(bus1.in_ready), 1);
    chk("rst_out_valid", 0, 32'(bus0.out_valid), 0);
    chk("rst_overflow", 1, 32'(ovf1), 0);

    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 16'(2 * k), 0);
      chk("fill_ready", 1, 32'(bus1.in_ready), 1);
    end
    cyc(0, 0, 1, 16'h8, 0);
    chk("full_count", 0, 32'(count0), 4);
    chk("full_count", 1, 32'(count1), 4);
    chk("full_in_ready", 1, 32'(bus1.in_ready), 0);

    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 16'h0, 1);
      if (k == 0) chk("ovf_set", 1, 32'(ovf1), 1);
      if (k == 1) chk("drain_ready", 0, 32'(bus0.in_ready), 1);
      chk("drain_pc", 0, 32'(bus0.out_pc), 32'(2 * k));
      chk("drain_pc", 1, 32'(bus1.out_pc), 32'(2 * k));
      chk("drain_count", 1, 32'(count1), 32'(4 - k));
    end

    cyc(0, 0, 1, 16'h0010, 1);
    chk("byp_count", 1, 32'(count1), 0);
    chk("byp_valid", 1, 32'(bus1.out_valid), 1);
    chk("byp_pc", 1, 32'(bus1.out_pc), 32'h10);
    chk("nobyp_valid", 0, 32'(bus0.out_valid), 0);
    cyc(0, 0, 0, 16'h0, 1);
    chk("byp_count_after", 1, 32'(count1), 0);
    chk("nobyp_count", 0, 32'(count0), 1);
    chk("nobyp_valid_next", 0, 32'(bus0.out_valid), 1);
    chk("nobyp_pc_next", 0, 32'(bus0.out_pc), 32'h10);

    cyc(0, 0, 1, 16'h0020, 0);
    cyc(0, 0, 1, 16'h0022, 0);
    cyc(0, 0, 1, 16'h0024, 0);
    cyc(0, 1, 1, 16'h0026, 1);
    chk("pre_flush_count", 1, 32'(count1), 3);
    chk("flush_valid", 1, 32'(bus1.out_valid), 0);
    chk("flush_ready", 0, 32'(bus0.in_ready), 0);
    cyc(0, 0, 0, 16'h0, 0);
    chk("post_flush_count", 0, 32'(count0), 0);
    chk("post_flush_count", 1, 32'(count1), 0);
    chk("post_flush_ovf", 1, 32'(ovf1), 0);
    chk("post_flush_valid", 0, 32'(bus0.out_valid), 0);

    cyc(0, 0, 1, 16'h0040, 0);
    cyc(0, 0, 1, 16'h0042, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 1, 16'(16'h44 + 2 * k), 1);
      chk("pp_count", 0, 32'(count0), 2);
      chk("pp_count", 1, 32'(count1), 2);
      chk("pp_pc", 0, 32'(bus0.out_pc), 32'(16'h40 + 2 * k));
      chk("pp_pc", 1, 32'(bus1.out_pc), 32'(16'h40 + 2 * k));
    end

    cyc(0, 0, 1, 16'h0050, 0);
    cyc(0, 0, 1, 16'h0052, 0);
    cyc(0, 0, 1, 16'h0054, 0);
    chk("mid_full", 0, 32'(bus0.in_ready), 0);
    cyc(0, 0, 0, 16'h0, 1);
    chk("mid_ovf", 0, 32'(ovf0), 1);
    cyc(1, 1, 1, 16'h0056, 1);
    chk("mid_count", 1, 32'(count1), 3);
    chk("mid_ovf_held", 1, 32'(ovf1), 1);
    cyc(0, 0, 0, 16'h0, 0);
    chk("rst2_count", 0, 32'(count0), 0);
    chk("rst2_count", 1, 32'(count1), 0);
    chk("rst2_ovf", 1, 32'(ovf1), 0);
    chk("rst2_ready", 1, 32'(bus1.in_ready), 1);
    cyc(0, 0, 0, 16'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 16, instruction word width in bits.
REQ-002 SHALL have parameter AW, default 16, PC width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-004 SHALL have parameter BYPASS, default 1, 1 = empty-queue fall-through, 0 = always registered.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port flush  input  1  branch-redirect discard of all queued and incoming entries.
REQ-008 SHALL have port in_valid  input  1  fetch offers an entry.
REQ-009 SHALL have port in_pc  input  AW  PC of offered entry.
REQ-010 SHALL have port in_instr  input  WIDTH  instruction of offered entry.
REQ-011 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-012 SHALL have port out_valid  output  1  entry presented to decode.
REQ-013 SHALL have port out_pc  output  AW  PC of presented entry.
REQ-014 SHALL have port out_instr  output  WIDTH  instruction of presented entry.
REQ-015 SHALL have port out_ready  input  1  decode not stalled; consumes presented entry.
REQ-016 SHALL have port count  output  clog2(DEPTH+1)  entries currently stored.
REQ-017 SHALL have port overflow  output  1  sticky: in_valid seen while in_ready low (flush cycles excluded).

Function
REQ-018 SHALL store DEPTH entries of {pc, instr} in circular storage with write and read pointers wrapping modulo DEPTH.
REQ-019 SHALL push when in_valid & in_ready; SHALL pop when out_valid & out_ready.
REQ-020 SHALL drive in_ready = (count != DEPTH) & !flush; no ready-on-pop combinational path when full.
REQ-021 SHALL, when count != 0, present the entry at read pointer with out_valid = 1, regardless of in_valid.
REQ-022 SHALL, when count == 0 and BYPASS = 1, drive out_valid = in_valid, out_pc = in_pc, out_instr = in_instr combinationally.
REQ-023 SHALL, in bypass with out_ready = 1, not write the entry (count stays 0); with out_ready = 0, write it (count -> 1).
REQ-024 SHALL, when count == 0 and BYPASS = 0, drive out_valid = 0; pushed entry appears next cycle.
REQ-025 SHALL, on simultaneous push and pop with count in 1..DEPTH-1, advance both pointers and hold count.
REQ-026 SHALL preserve FIFO order; out_pc/out_instr SHALL hold stable while out_valid & !out_ready.
REQ-027 SHALL, when flush = 1, force out_valid = 0 and in_ready = 0 that cycle, drop in_valid, and next cycle have count = 0, pointers = 0.
REQ-028 SHALL clear overflow on flush; flush SHALL NOT set overflow.
REQ-029 SHALL set overflow next cycle when in_valid & !in_ready & !flush; entry dropped, state otherwise unchanged.
REQ-030 SHALL drive out_pc/out_instr don't-care when out_valid = 0; bench SHALL NOT check them then.

Reset
REQ-031 SHALL on reset = 1 at a rising edge set count = 0, pointers = 0, overflow = 0; reset SHALL override flush, push and pop that cycle.
REQ-032 SHALL after reset present in_ready = 1 and out_valid = in_valid (BYPASS = 1) or 0 (BYPASS = 0).
REQ-033 SHALL NOT require storage contents to be reset.

Verification
REQ-034 SHALL cover fill: out_ready = 0, push pc 0,2,4,6 -> count 4, in_ready 0; 5th push (pc 8) -> dropped, overflow = 1 next cycle.
REQ-035 SHALL cover drain: from full, out_ready = 1 four cycles -> out_pc 0,2,4,6 in order, count 3,2,1,0, in_ready 1 after first pop.
REQ-036 SHALL cover bypass: BYPASS = 1, empty, in_valid with pc 0x0010, out_ready = 1 -> out_valid same cycle, out_pc 0x0010, count stays 0; BYPASS = 0 -> out_valid next cycle.
REQ-037 SHALL cover flush: count 3, flush with in_valid = 1 -> out_valid 0 that cycle, count 0 next cycle, incoming entry absent, overflow cleared.
REQ-038 SHALL cover simultaneous push/pop: count 2, push + pop 6 cycles -> count 2 throughout, pointers wrap, order preserved.
REQ-039 SHALL cover reset mid-operation: count 3, overflow 1, reset with flush and in_valid -> count 0, overflow 0, in_ready 1 next cycle.
